// File: rtl/divider_seq.sv
// -----------------------------------------------------------------------------
// divider_seq -- sequential restoring divider, one quotient bit per cycle.
//
// Signed (two's-complement, truncating toward zero) or unsigned divide of two
// WIDTH-bit operands. Operands are captured when start is accepted in IDLE;
// the result appears WIDTH+1 edges later with a one-cycle done pulse. A zero
// divisor short-circuits to a one-edge result: quot = all ones, rem = dividend.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        request, sampled only while idle
//   is_signed    1 = signed divide, 0 = unsigned (captured with start)
//   dividend     numerator   (captured with start)
//   divisor      denominator (captured with start)
//   quot         quotient, registered, held until the next completion
//   rem          remainder, registered, held until the next completion
//   busy         high while an operation is in flight
//   done         single-cycle completion pulse
//   div_by_zero  set with done for a zero divisor, held until next acceptance
// -----------------------------------------------------------------------------
module divider_seq #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, ZERO} state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd;      // dividend magnitude, shifts out MSB-first; quotient shifts in
  logic [WIDTH-1:0] dvs;      // divisor magnitude
  logic [WIDTH-1:0] prem;     // partial remainder (always < dvs, so WIDTH bits hold it)
  logic             sgn;
  logic             neg_dvd;
  logic             neg_dvs;

  logic [WIDTH:0]   shifted;  // WIDTH+1-bit partial remainder after shifting in a bit
  logic [WIDTH-1:0] trial;
  logic             qbit;

  // Two's-complement negation modulo 2^WIDTH; the minimum value maps to itself.
  function automatic logic [WIDTH-1:0] neg2(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic en);
    return en ? neg2(v) : v;
  endfunction

  // One restoring step. When shifted >= dvs the difference is below dvs, so
  // the low WIDTH bits of the subtraction are exact.
  always_comb begin
    shifted = {prem, dvd[WIDTH-1]};
    qbit    = (shifted >= {1'b0, dvs});
    trial   = shifted[WIDTH-1:0] - dvs;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = (divisor == '0) ? ZERO : CALC;
      CALC: if (cnt == '0) state_next = FIX;
      FIX:  state_next = IDLE;
      ZERO: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      prem        <= '0;
      sgn         <= 1'b0;
      neg_dvd     <= 1'b0;
      neg_dvs     <= 1'b0;
      quot        <= '0;
      rem         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sgn         <= is_signed;
            neg_dvd     <= is_signed & dividend[WIDTH-1];
            neg_dvs     <= is_signed & divisor[WIDTH-1];
            // A zero divisor reports the raw dividend, so keep it unconverted.
            dvd         <= (divisor == '0) ? dividend
                                           : cond_neg(dividend, is_signed & dividend[WIDTH-1]);
            dvs         <= cond_neg(divisor, is_signed & divisor[WIDTH-1]);
            prem        <= '0;
            cnt         <= CNT_W'(WIDTH - 1);
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
          end
        end
        CALC: begin
          prem <= qbit ? trial : shifted[WIDTH-1:0];
          dvd  <= {dvd[WIDTH-2:0], qbit};
          cnt  <= cnt - CNT_W'(1);
        end
        FIX: begin
          quot <= cond_neg(dvd, sgn & (neg_dvd ^ neg_dvs));
          rem  <= cond_neg(prem, sgn & neg_dvd);
          done <= 1'b1;
          busy <= 1'b0;
        end
        ZERO: begin
          quot        <= '1;
          rem         <= dvd;
          div_by_zero <= 1'b1;
          done        <= 1'b1;
          busy        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_seq.sv
// -----------------------------------------------------------------------------
// tb_divider_seq -- directed self-checking bench for divider_seq (WIDTH=64).
// -----------------------------------------------------------------------------
module tb_divider_seq;
  localparam int W = 64;
  localparam logic [W-1:0] MINV = 64'h8000_0000_0000_0000;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quot;
  logic [W-1:0] rem;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int passed = 0;
  int total  = 0;

  divider_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .quot(quot), .rem(rem),
    .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Present operands for one edge; scramble them afterwards so any late
  // sampling by the design would corrupt the result.
  task automatic launch(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    is_signed = s; dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; is_signed = ~s; dividend = ~a; divisor = '0;
  endtask

  // Called #1 after the acceptance edge; counts edges until done.
  task automatic wait_done(input int limit, output int l, output bit bok);
    l = 0; bok = 1'b1;
    while (done !== 1'b1 && l < limit) begin
      if (busy !== 1'b1) bok = 1'b0;
      @(posedge clk); #1;
      l++;
    end
    if (busy !== 1'b0) bok = 1'b0;
  endtask

  task automatic run(input string tag, input logic s, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] eq,
                     input logic [W-1:0] er, input int elat);
    int  l;
    bit  bok;
    launch(s, a, b);
    wait_done(200, l, bok);
    chk({tag, "_quot"}, quot, eq);
    chk({tag, "_rem"},  rem,  er);
    chk({tag, "_lat"},  W'(l), W'(elat));
    chk({tag, "_busy"}, W'(bok), W'(1));
  endtask

  initial begin
    int  l;
    bit  bok;
    int  ndone;
    int  dlat;
    logic [W-1:0] q_s, r_s;

    rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_quot", quot, '0);
    chk("rst_rem",  rem,  '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_dbz",  W'(div_by_zero), '0);
    @(negedge clk) rst = 1'b0;

    run("u100_7", 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 65);
    chk("u100_7_dbz", W'(div_by_zero), '0);
    run("sn100_7", 1'b1, -64'd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, -64'd2, 65);
    run("s100_n7", 1'b1, 64'd100, -64'd7, -64'd14, 64'd2, 65);
    run("s_ovf", 1'b1, MINV, '1, MINV, '0, 65);
    run("u_ovf", 1'b0, MINV, '1, '0, MINV, 65);
    run("dz", 1'b1, 64'h1234, '0, '1, 64'h1234, 1);
    chk("dz_flag", W'(div_by_zero), W'(1));
    @(posedge clk); #1;
    chk("dz_hold", W'(div_by_zero), W'(1));
    chk("dz_pulse", W'(done), '0);

    // Start re-pulsed with new operands mid-operation must be ignored.
    launch(1'b0, '1, '1);
    ndone = 0; dlat = -1; q_s = 'x; r_s = 'x;
    for (int i = 1; i <= 90; i++) begin
      @(posedge clk); #1;
      if (i == 9) begin
        start = 1'b1; is_signed = 1'b1; dividend = 64'd5; divisor = '0;
      end else if (i == 10) begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin dlat = i; q_s = quot; r_s = rem; end
      end
    end
    chk("ign_ndone", W'(ndone), W'(1));
    chk("ign_lat",   W'(dlat),  W'(65));
    chk("ign_quot",  q_s, W'(1));
    chk("ign_rem",   r_s, '0);
    chk("ign_dbz",   W'(div_by_zero), '0);

    // Reset in the middle of CALC aborts silently.
    launch(1'b0, 64'd100, 64'd7);
    repeat (29) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("mrst_quot", quot, '0);
    chk("mrst_rem",  rem,  '0);
    chk("mrst_busy", W'(busy), '0);
    chk("mrst_done", W'(done), '0);
    @(negedge clk) rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
    chk("mrst_nodone", W'(ndone), '0);
    run("u9_3", 1'b0, 64'd9, 64'd3, 64'd3, 64'd0, 65);

    // Start held high: re-accepted in the idle cycle after done.
    @(negedge clk);
    is_signed = 1'b0; dividend = 64'd20; divisor = 64'd6; start = 1'b1;
    @(posedge clk); #1;
    wait_done(200, l, bok);
    chk("b2b1_quot", quot, 64'd3);
    chk("b2b1_rem",  rem,  64'd2);
    chk("b2b1_lat",  W'(l), W'(65));
    @(posedge clk); #1;
    chk("b2b_rebusy", W'(busy), W'(1));
    chk("b2b_redone", W'(done), '0);
    start = 1'b0; dividend = 64'd1; divisor = 64'd1;
    wait_done(200, l, bok);
    chk("b2b2_quot", quot, 64'd3);
    chk("b2b2_rem",  rem,  64'd2);
    chk("b2b2_lat",  W'(l), W'(65));
    chk("b2b2_busy", W'(bok), W'(1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/divider_seq.md
DIVIDER_SEQ -- requirements
Module: divider_seq

Interface
REQ-001 Parameter: WIDTH, default 64, operand and result width in bits.
REQ-002 The block SHALL use one clock and one reset: reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 is_signed  input  1  1 = two's-complement divide, 0 = unsigned; latched with start.
REQ-007 dividend  input  WIDTH  numerator; latched with start.
REQ-008 divisor  input  WIDTH  denominator; latched with start.
REQ-009 quot  output  WIDTH  quotient, registered, held until the next completion.
REQ-010 rem  output  WIDTH  remainder, registered, held until the next completion.
REQ-011 busy  output  1  high from the edge after start is accepted until the edge that raises done.
REQ-012 done  output  1  single-cycle pulse; quot and rem are valid from this cycle on.
REQ-013 div_by_zero  output  1  set with done when the latched divisor was 0; held until the next acceptance.

Function
REQ-014 FSM states SHALL be IDLE, CALC, FIX and ZERO; the reset state SHALL be IDLE.
REQ-015 IDLE with start=1 SHALL accept: latch is_signed and the operand signs, latch |dividend| and |divisor| (magnitude only when is_signed=1), clear the partial remainder, load iteration count WIDTH-1, set busy, and clear div_by_zero.
REQ-016 At acceptance, divisor==0 SHALL transition to ZERO; any other divisor SHALL transition to CALC.
REQ-017 CALC SHALL run one restoring-division step per cycle, MSB first, over a WIDTH+1-bit partial remainder: shift in the next dividend bit, trial-subtract the divisor, and set the quotient bit when the result is non-negative.
REQ-018 CALC SHALL last exactly WIDTH cycles and SHALL then transition to FIX.
REQ-019 FIX SHALL negate the quotient when the signs differ and is_signed=1.
REQ-020 FIX SHALL negate the remainder when the dividend was negative and is_signed=1, so the remainder takes the sign of the dividend and the quotient truncates toward zero.
REQ-021 FIX SHALL register quot and rem, pulse done, clear busy, and return to IDLE.
REQ-022 Latency: done SHALL assert in the cycle after the (WIDTH+1)th rising edge following the acceptance edge, i.e. 65 cycles for WIDTH=64.
REQ-023 ZERO SHALL take one cycle and SHALL set quot to all ones, rem to the raw latched dividend, div_by_zero=1 and done=1, then return to IDLE; latency is 1 edge after acceptance.
REQ-024 Signed overflow (minimum negative / -1) SHALL yield quot = minimum negative value and rem = 0, with no extra flag.
REQ-025 start while busy=1 SHALL be ignored, with no effect on the operation in progress.
REQ-026 start held high continuously SHALL be re-accepted in the IDLE cycle that follows done, giving back-to-back operations.
REQ-027 Input changes after acceptance SHALL NOT affect the result.
REQ-028 Arithmetic SHALL be modulo 2^WIDTH, and the negation of the minimum negative value SHALL be that same value.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, busy=0, done=0, div_by_zero=0, quot=0, rem=0, and internal counter/registers to 0, independent of clk.
REQ-030 rst asserted mid-CALC or mid-FIX SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Verification
REQ-031 Unsigned 100 / 7 -> quot=14, rem=2, done 65 cycles after start, busy high for the whole interval.
REQ-032 Signed -100 / 7 -> quot=-14 (0xFFFF_FFFF_FFFF_FFF2), rem=-2; signed 100 / -7 -> quot=-14, rem=2.
REQ-033 Signed 0x8000_0000_0000_0000 / 0xFFFF_FFFF_FFFF_FFFF -> quot=0x8000_0000_0000_0000, rem=0; the same operands unsigned -> quot=0, rem=0x8000_0000_0000_0000.
REQ-034 Divisor 0 with dividend 0x1234 -> done after 1 edge, div_by_zero=1, quot=0xFFFF_FFFF_FFFF_FFFF, rem=0x1234.
REQ-035 Unsigned 0xFFFF_FFFF_FFFF_FFFF / 0xFFFF_FFFF_FFFF_FFFF -> quot=1, rem=0; a second start pulsed at cycle 10 is ignored; only one done pulse occurs.
REQ-036 rst pulsed at cycle 30 of a CALC -> no done pulse, all outputs 0; a new 9/3 request then returns quot=3, rem=0.
